uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two byte sources: src0 is metadata_sender and src1 is the sample-dump sender. A source wins the transmitter for a whole burst and keeps it until its active signal drops. While a source holds the grant, the block forwards that source's bytes one at a time. Each byte completes a full tran_data / tx_busy handshake before the next byte is accepted. The block sits between the sources and the UART transmitter.

---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-source UART transmit arbiter with burst-level grants and a one-cycle registered strobe from owner request to UART.
// Backpressure: the owner sees tx_busy in GRANTED, otherwise busy; optional macro TX_ARB_ACK_TIMEOUT_EN aborts unacknowledged bytes.
module uart_tx_arbiter #(
    parameter int ACK_TIMEOUT = 16,
    parameter int START_PRIO  = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       src0_active,
    input  logic       src0_tran_data,
    input  logic [7:0] src0_byte,
    output logic       src0_tx_busy,
    input  logic       src1_active,
    input  logic       src1_tran_data,
    input  logic [7:0] src1_byte,
    output logic       src1_tx_busy,
    input  logic       tx_busy,
    output logic [7:0] transmit_byte,
    output logic       tran_data,
    output logic [1:0] grant,
    output logic       arb_busy,
    output logic       ack_timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANTED   = 2'd1,
        WAIT_RISE = 2'd2,
        WAIT_FALL = 2'd3
    } state_t;

    // last_grant holds the index of the previous owner; seeded so START_PRIO wins the first tie
    localparam logic LAST_RST = (START_PRIO == 0);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic       tran_data_q, tran_data_d;
    logic [7:0] byte_q, byte_d;

    logic       owner_idx;
    logic       own_active;
    logic       own_req;
    logic [7:0] own_byte;
    logic       timeout_hit;

    assign owner_idx  = grant_q[1];
    assign own_active = owner_idx ? src1_active    : src0_active;
    assign own_req    = owner_idx ? src1_tran_data : src0_tran_data;
    assign own_byte   = owner_idx ? src1_byte      : src0_byte;

`ifdef TX_ARB_ACK_TIMEOUT_EN
    localparam int            CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    assign timeout_hit = (state_q == WAIT_RISE) && !tx_busy && (cnt_q == CNT_LAST);

    // Counter is held at zero outside WAIT_RISE so every entry starts fresh
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != WAIT_RISE) begin
            cnt_d = '0;
        end else if (!tx_busy && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= timeout_hit;
        end
    end

    assign ack_timeout_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout  = (ACK_TIMEOUT != 0);
    assign timeout_hit     = 1'b0;
    assign ack_timeout_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tran_data_d  = 1'b0;
        byte_d       = byte_q;
        case (state_q)
            IDLE: begin
                if (src0_active && src1_active) begin
                    grant_d = last_grant_q ? 2'b01 : 2'b10;
                    state_d = GRANTED;
                end else if (src0_active) begin
                    grant_d = 2'b01;
                    state_d = GRANTED;
                end else if (src1_active) begin
                    grant_d = 2'b10;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                // A pending byte takes precedence over the end of the burst
                if (own_req && !tx_busy) begin
                    byte_d      = own_byte;
                    tran_data_d = 1'b1;
                    state_d     = WAIT_RISE;
                end else if (!own_active) begin
                    last_grant_d = owner_idx;
                    grant_d      = 2'b00;
                    state_d      = IDLE;
                end
            end
            WAIT_RISE: begin
                if (tx_busy) begin
                    state_d = WAIT_FALL;
                end else if (timeout_hit) begin
                    state_d = GRANTED;
                end
            end
            WAIT_FALL: begin
                if (!tx_busy) begin
                    state_d = GRANTED;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= LAST_RST;
            tran_data_q  <= 1'b0;
            byte_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tran_data_q  <= tran_data_d;
            byte_q       <= byte_d;
        end
    end

    assign src0_tx_busy  = (state_q == GRANTED && grant_q[0]) ? tx_busy : 1'b1;
    assign src1_tx_busy  = (state_q == GRANTED && grant_q[1]) ? tx_busy : 1'b1;
    assign arb_busy      = (state_q != IDLE);
    assign tran_data     = tran_data_q;
    assign transmit_byte = byte_q;
    assign grant         = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: bursts, round-robin, non-owner masking, ack timeout, async reset, held request.
module tb_uart_tx_arbiter;

    logic       clock;
    logic       reset;
    logic       src0_active, src0_tran_data;
    logic [7:0] src0_byte;
    logic       src0_tx_busy;
    logic       src1_active, src1_tran_data;
    logic [7:0] src1_byte;
    logic       src1_tx_busy;
    logic       tx_busy;
    logic [7:0] transmit_byte;
    logic       tran_data;
    logic [1:0] grant;
    logic       arb_busy;
    logic       ack_timeout_err;

    int total = 0;
    int bad   = 0;

    // UART model: busy rises one cycle after a strobe and stays high 10 cycles
    logic uart_en;
    logic man_busy;
    logic mdl_busy = 1'b0;
    logic pend     = 1'b0;
    int   hold     = 0;
    assign tx_busy = uart_en ? mdl_busy : man_busy;

    // Monitor state, written only by the monitor process
    int         scnt   = 0;
    int         b2b    = 0;
    int         ffcnt  = 0;
    int         errcnt = 0;
    int         viol   = 0;
    logic       prev_td = 1'b0;
    logic       win0;
    logic [7:0] bytes [64];

    uart_tx_arbiter #(.ACK_TIMEOUT(16), .START_PRIO(0)) dut (
        .clock           (clock),
        .reset           (reset),
        .src0_active     (src0_active),
        .src0_tran_data  (src0_tran_data),
        .src0_byte       (src0_byte),
        .src0_tx_busy    (src0_tx_busy),
        .src1_active     (src1_active),
        .src1_tran_data  (src1_tran_data),
        .src1_byte       (src1_byte),
        .src1_tx_busy    (src1_tx_busy),
        .tx_busy         (tx_busy),
        .transmit_byte   (transmit_byte),
        .tran_data       (tran_data),
        .grant           (grant),
        .arb_busy        (arb_busy),
        .ack_timeout_err (ack_timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always begin
        @(posedge clock);
        #1;
        if (uart_en) begin
            if (hold > 0) begin
                hold = hold - 1;
                if (hold == 0) mdl_busy = 1'b0;
            end else if (pend) begin
                pend     = 1'b0;
                mdl_busy = 1'b1;
                hold     = 10;
            end
            if (tran_data) pend = 1'b1;
        end
    end

    always begin
        @(posedge clock);
        #1;
        if (tran_data) begin
            bytes[scnt % 64] = transmit_byte;
            scnt = scnt + 1;
            if (transmit_byte == 8'hFF) ffcnt = ffcnt + 1;
        end
        if (tran_data && prev_td) b2b = b2b + 1;
        prev_td = tran_data;
        if (ack_timeout_err) errcnt = errcnt + 1;
        if (win0 && (grant !== 2'b01 || src1_tx_busy !== 1'b1)) viol = viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int s, input logic [7:0] b);
        int n;
        if (s == 0) begin
            src0_byte      = b;
            src0_tran_data = 1'b1;
        end else begin
            src1_byte      = b;
            src1_tran_data = 1'b1;
        end
        n = 0;
        do begin
            tick(1);
            n++;
        end while (tran_data !== 1'b1 && n < 50);
        chk("send_strobe", tran_data, 1);
        chk("send_byte", transmit_byte, b);
        src0_tran_data = 1'b0;
        src1_tran_data = 1'b0;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (((s == 0) ? src0_tx_busy : src1_tx_busy) !== 1'b0 && n < 100);
        chk("send_done", (s == 0) ? src0_tx_busy : src1_tx_busy, 0);
    endtask

    initial begin
        int base;
        int k;
        int v;
        reset          = 1'b1;
        src0_active    = 1'b0;
        src0_tran_data = 1'b0;
        src0_byte      = 8'h00;
        src1_active    = 1'b0;
        src1_tran_data = 1'b0;
        src1_byte      = 8'h00;
        uart_en        = 1'b1;
        man_busy       = 1'b0;
        win0           = 1'b0;

        // Reset values, sampled before the first clock edge
        #3 reset = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_tran_data", tran_data, 0);
        chk("rst_byte", transmit_byte, 8'h00);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_err", ack_timeout_err, 0);
        chk("rst_s0_busy", src0_tx_busy, 1);
        chk("rst_s1_busy", src1_tx_busy, 1);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("idle_grant", grant, 2'b00);

        // Single src0 burst, with src1 pulsing a request mid-burst
        src0_active = 1'b1;
        tick(1);
        chk("t1_grant", grant, 2'b01);
        chk("t1_arb_busy", arb_busy, 1);
        chk("t1_s0_busy", src0_tx_busy, 0);
        win0 = 1'b1;
        base = scnt;
        send(0, 8'hA5);
        k = scnt;
        src1_byte      = 8'hFF;
        src1_tran_data = 1'b1;
        tick(3);
        src1_tran_data = 1'b0;
        chk("t3_no_strobe", scnt - k, 0);
        chk("t3_grant", grant, 2'b01);
        send(0, 8'h5A);
        send(0, 8'h3C);
        win0 = 1'b0;
        src0_active = 1'b0;
        tick(1);
        chk("t1_release", grant, 2'b00);
        chk("t1_idle", arb_busy, 0);
        chk("t1_count", scnt - base, 3);
        chk("t1_b0", bytes[base % 64], 8'hA5);
        chk("t1_b1", bytes[(base + 1) % 64], 8'h5A);
        chk("t1_b2", bytes[(base + 2) % 64], 8'h3C);
        chk("t1_b2b", b2b, 0);
        chk("t1_window", viol, 0);
        chk("t3_no_ff", ffcnt, 0);

        // Round-robin from a fresh reset
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        src0_active = 1'b1;
        src1_active = 1'b1;
        tick(1);
        chk("t2_first", grant, 2'b01);
        send(0, 8'h10);
        src0_active = 1'b0;
        tick(1);
        chk("t2_idle", grant, 2'b00);
        tick(1);
        chk("t2_second", grant, 2'b10);
        chk("t2_s0_masked", src0_tx_busy, 1);
        chk("t2_s1_open", src1_tx_busy, 0);
        send(1, 8'h20);
        chk("t2_byte", transmit_byte, 8'h20);
        src1_active = 1'b0;
        tick(2);
        src0_active = 1'b1;
        src1_active = 1'b1;
        tick(1);
        chk("t2_third", grant, 2'b01);
        src0_active = 1'b0;
        tick(2);
        chk("t2_fourth", grant, 2'b10);
        src1_active = 1'b0;
        tick(2);
        chk("t2_end", grant, 2'b00);

        // Unacknowledged byte
        src0_active = 1'b1;
        tick(1);
        chk("t4_grant", grant, 2'b01);
        uart_en   = 1'b0;
        base      = errcnt;
        src0_byte      = 8'h11;
        src0_tran_data = 1'b1;
        tick(1);
        src0_tran_data = 1'b0;
        chk("t4_strobe", tran_data, 1);
`ifdef TX_ARB_ACK_TIMEOUT_EN
        k = 0;
        do begin
            tick(1);
            k++;
        end while (ack_timeout_err !== 1'b1 && k < 40);
        chk("t4_timeout_cycles", k, 16);
        tick(3);
        chk("t4_one_pulse", errcnt - base, 1);
        chk("t4_back_granted", src0_tx_busy, 0);
`else
        v = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (src0_tx_busy !== 1'b1) v++;
        end
        chk("t4_stuck_busy", v, 0);
        chk("t4_no_err", errcnt - base, 0);
        man_busy = 1'b1;
        tick(1);
        man_busy = 1'b0;
        tick(1);
        chk("t4_recovered", src0_tx_busy, 0);
`endif
        uart_en = 1'b1;
        send(0, 8'h22);

        // Held request: one strobe every 13 cycles of the UART model
        base = scnt;
        k    = b2b;
        src0_byte      = 8'h66;
        src0_tran_data = 1'b1;
        tick(40);
        src0_tran_data = 1'b0;
        chk("t6_count", scnt - base, 4);
        chk("t6_no_b2b", b2b - k, 0);
        v = 0;
        do begin
            tick(1);
            v++;
        end while (src0_tx_busy !== 1'b0 && v < 100);
        chk("t6_settled", src0_tx_busy, 0);

        // Reset while the byte is in WAIT_FALL
        src0_byte      = 8'h77;
        src0_tran_data = 1'b1;
        v = 0;
        do begin
            tick(1);
            v++;
        end while (tran_data !== 1'b1 && v < 50);
        src0_tran_data = 1'b0;
        tick(2);
        chk("t5_pre_byte", transmit_byte, 8'h77);
        chk("t5_pre_busy", arb_busy, 1);
        reset = 1'b0;
        #1;
        chk("t5_grant", grant, 2'b00);
        chk("t5_tran_data", tran_data, 0);
        chk("t5_byte", transmit_byte, 8'h00);
        chk("t5_s0_busy", src0_tx_busy, 1);
        chk("t5_s1_busy", src1_tx_busy, 1);
        chk("t5_arb_busy", arb_busy, 0);
        tick(1);
        reset       = 1'b1;
        src0_active = 1'b0;
        src1_active = 1'b1;
        tick(1);
        chk("t5_src1_grant", grant, 2'b10);
        src1_active = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
